lif_neuron_array: RTL and testbench
===================================

Name: lif_neuron_array

Overview:
Parametrised array of N_CH independent leaky integrate-and-fire neurons sharing one clock, enable and firing threshold.
- Per channel: membrane potential integrates synaptic current, leaks by arithmetic right shift, saturates at full scale.
- Each spike is a one-cycle pulse, followed by a programmable refractory period.
- Sits between the synaptic-current front end and the spike router/encoder; also gives debug readback of any channel's membrane potential.

Parameters:
N_CH, 4, number of neuron channels (>=1)
W, 8, membrane potential / synaptic current width in bits (>=2)
LEAK_SHIFT, 2, leak term = v >> LEAK_SHIFT (1..W-1)
REFRACT, 8, refractory length in enabled cycles after a spike (0 = none)
SEL_W, max(1,clog2(N_CH)), width of readback select

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-high
en  in  1  global enable; 0 freezes all state
in_valid  in  1  isyn qualifies this cycle; 0 = treat all isyn as 0
isyn  in  N_CH*W  synaptic currents, channel i at bits [i*W +: W], unsigned
threshold  in  W  common firing threshold, unsigned
spike  out  N_CH  registered one-cycle spike pulse per channel
refractory  out  N_CH  registered, 1 while channel's refractory counter != 0
vmem_sel  in  SEL_W  channel select for readback
vmem_out  out  W  registered membrane potential of selected channel (1-cycle latency)

Behaviour:
- Reset (rst_n=1, async): all v=0, refractory counters=0, spike=0, refractory=0, vmem_out=0. Reset mid-refractory aborts it; after release, channels integrate immediately.
- en=0: v, counters and vmem_out hold; spike forced 0 on the next edge.
- Per channel, each rising edge with en=1:
  - Refractory (cnt!=0): cnt<=cnt-1; v held at 0; input ignored; spike<=0.
  - Otherwise:
    - a = (in_valid ? isyn_i : 0)
    - vn = v - (v>>LEAK_SHIFT) + a, computed in W+1 bits, saturated to 2^W-1.
    - If vn >= threshold: spike<=1, v<=0, cnt<=REFRACT.
    - Else: v<=vn, spike<=0.
- Latency: a crossing computed at edge k gives spike=1 during cycle k..k+1; the first refractory edge is k+1.
- REFRACT=0: a channel may fire on consecutive cycles.
- threshold=0: every non-refractory enabled cycle fires. This is legal and defined.
- Leak truncates toward zero; with a=0, v settles at the largest value with v>>LEAK_SHIFT == 0 (no decay to 0 guaranteed).
- Saturation: vn never wraps; a clamp to 2^W-1 still compares against threshold.
- Channels are fully independent; simultaneous spikes on any subset are allowed.
- vmem_out <= v[vmem_sel] (pre-update value) every enabled edge. vmem_sel >= N_CH yields 0.
- refractory output reflects the post-edge counter (cnt!=0).
- threshold and isyn are sampled each edge; there is no latching.

Decomposition:
- Package lif_pkg: default W/LEAK_SHIFT/REFRACT constants, a function for the refractory counter width (clog2(REFRACT+1), min 1), and a saturating-add helper function.
- Sub-module lif_neuron_core: one channel (v register, leak/sat datapath, compare, refractory counter). Instantiated N_CH times via generate.
- Readback mux stays in the top.

Test Plan:
- Integrate/fire (W=8, LEAK_SHIFT=2, REFRACT=3, threshold=100, ch0 isyn=30, in_valid=1):
  - v after edges 1..5 = 30,53,70,83,93; edge6 vn=100 -> spike[0]=1 for one cycle, v=0.
  - refractory=1 for edges 6..8; edge9 refractory=0, v=0; edge10 v=30.
- Leak decay:
  - One cycle isyn=80, then in_valid=0, threshold=100.
  - vmem_out tracks 80,60,45,34,26,20,15,12,9,7,6,5,4,3,3 (one cycle late); no spike.
- Saturation (threshold=255, ch1 isyn=200):
  - edge1 v=200; edge2 vn=350 clamps to 255 -> spike[1]=1, v=0.
  - No wrap to 94.
- Independence/simultaneity (N_CH=4, threshold=50):
  - isyn={60,0,50,49}, one cycle -> spike=4'b0101 same cycle; ch3 v=49, ch1 v=0.
- Enable freeze:
  - Mid-integration (v=53), en=0 for 5 cycles: v, refractory counters and vmem_out unchanged; spike=0.
  - After en=1, sequence resumes at 70.
- Async reset mid-refractory:
  - rst_n pulsed between clock edges when cnt=2: outputs 0 immediately, without waiting for a clock edge.
  - After release, isyn=30 gives v=30 at the first edge; no residual refractory.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared constants and helpers for the leaky integrate-and-fire neuron array.
package lif_pkg;

    localparam int DEF_W          = 8;
    localparam int DEF_LEAK_SHIFT = 2;
    localparam int DEF_REFRACT    = 8;

    // Width of a down-counter that must hold REFRACT; never narrower than 1 bit.
    function automatic int refract_cnt_width(input int refract);
        int w;
        w = (refract <= 0) ? 1 : $clog2(refract + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Unsigned add clamped to 2^width-1 (width < 32).
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned  width);
        logic [32:0] s;
        logic [32:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << width) - 33'd1;
        return (s > lim) ? lim[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/lif_neuron_core.sv
// One LIF channel: membrane register, leak/saturating integrate, threshold
// compare and refractory down-counter.
module lif_neuron_core
    import lif_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int REFRACT    = DEF_REFRACT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         in_valid,
    input  logic [W-1:0] isyn,
    input  logic [W-1:0] threshold,
    output logic         spike,
    output logic         refractory,
    output logic [W-1:0] v
);

    localparam int            CW       = refract_cnt_width(REFRACT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(REFRACT);

    logic [CW-1:0] cnt;
    logic [W-1:0]  a;
    logic [W-1:0]  leaked;
    logic [W-1:0]  vn;

    assign a      = in_valid ? isyn : '0;
    // v - (v >> LEAK_SHIFT) can never underflow, so W bits suffice before the add.
    assign leaked = v - (v >> LEAK_SHIFT);
    assign vn     = W'(sat_add(32'(leaked), 32'(a), W));

    assign refractory = (cnt != '0);

    // Membrane, spike and refractory state; reset is asserted while rst_n is high.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            v     <= '0;
            cnt   <= '0;
            spike <= 1'b0;
        end else if (en) begin
            if (cnt != '0) begin
                cnt   <= cnt - CW'(1);
                v     <= '0;
                spike <= 1'b0;
            end else if (vn >= threshold) begin
                spike <= 1'b1;
                v     <= '0;
                cnt   <= CNT_LOAD;
            end else begin
                v     <= vn;
                spike <= 1'b0;
            end
        end else begin
            spike <= 1'b0;
        end
    end

endmodule

// File: rtl/lif_neuron_array.sv
// Array of N_CH independent LIF neurons with shared enable/threshold and a
// registered membrane-potential readback port.
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int W          = DEF_W,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int REFRACT    = DEF_REFRACT,
    parameter int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic [N_CH*W-1:0] isyn,
    input  logic [W-1:0]      threshold,
    output logic [N_CH-1:0]   spike,
    output logic [N_CH-1:0]   refractory,
    input  logic [SEL_W-1:0]  vmem_sel,
    output logic [W-1:0]      vmem_out
);

    logic [W-1:0] v_all [N_CH];
    logic [W-1:0] sel_v;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        lif_neuron_core #(
            .W         (W),
            .LEAK_SHIFT(LEAK_SHIFT),
            .REFRACT   (REFRACT)
        ) u_core (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .in_valid  (in_valid),
            .isyn      (isyn[g*W +: W]),
            .threshold (threshold),
            .spike     (spike[g]),
            .refractory(refractory[g]),
            .v         (v_all[g])
        );
    end

    // Select the addressed channel; out-of-range selects read as zero.
    always_comb begin
        sel_v = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (vmem_sel == SEL_W'(i)) sel_v = v_all[i];
        end
    end

    // Readback register captures the pre-update potential on enabled edges.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) vmem_out <= '0;
        else if (en) vmem_out <= sel_v;
    end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed self-checking bench for lif_neuron_array (N_CH=4, W=8, LEAK_SHIFT=2, REFRACT=3).
module tb_lif_neuron_array;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        in_valid;
    logic [31:0] isyn;
    logic [7:0]  threshold;
    logic [3:0]  spike;
    logic [3:0]  refractory;
    logic [1:0]  vmem_sel;
    logic [7:0]  vmem_out;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        en;
        logic        iv;
        logic [31:0] isyn;
        logic [7:0]  thr;
        logic [1:0]  sel;
        logic [3:0]  sp;
        logic [3:0]  rf;
        logic [7:0]  vm;
    } vec_t;

    vec_t tbl[11];
    int   leak_exp[15];

    lif_neuron_array #(
        .N_CH      (4),
        .W         (8),
        .LEAK_SHIFT(2),
        .REFRACT   (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .isyn      (isyn),
        .threshold (threshold),
        .spike     (spike),
        .refractory(refractory),
        .vmem_sel  (vmem_sel),
        .vmem_out  (vmem_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic iv, input logic [31:0] s,
                         input logic [7:0] thr, input logic [1:0] sel);
        en = e; in_valid = iv; isyn = s; threshold = thr; vmem_sel = sel;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 32'd0, 8'd100, 2'd0);
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
    endtask

    initial begin
        // Integrate/fire: ch0 isyn=30, threshold=100; rows hold post-edge outputs.
        for (int k = 0; k < 11; k++)
            tbl[k] = '{1'b1, 1'b1, 32'd30, 8'd100, 2'd0, 4'b0000, 4'b0000, 8'd0};
        tbl[1].vm  = 8'd30;
        tbl[2].vm  = 8'd53;
        tbl[3].vm  = 8'd70;
        tbl[4].vm  = 8'd83;
        tbl[5].vm  = 8'd93; tbl[5].sp = 4'b0001; tbl[5].rf = 4'b0001;
        tbl[6].rf  = 4'b0001;
        tbl[7].rf  = 4'b0001;
        tbl[10].vm = 8'd30;

        leak_exp = '{80, 60, 45, 34, 26, 20, 15, 12, 9, 7, 6, 5, 4, 3, 3};

        // Reset state.
        drive(1'b1, 1'b1, 32'h0505_0505, 8'd0, 2'd0);
        rst_n = 1'b1;
        repeat (2) step();
        check("reset_spike", spike, 4'b0000);
        check("reset_refr", refractory, 4'b0000);
        check("reset_vmem", vmem_out, 8'd0);

        // Integrate and fire.
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 32'd0, 8'd100, 2'd0);
        for (int k = 0; k < 11; k++) begin
            drive(tbl[k].en, tbl[k].iv, tbl[k].isyn, tbl[k].thr, tbl[k].sel);
            step();
            check($sformatf("if_spike_e%0d", k + 1), spike, tbl[k].sp);
            check($sformatf("if_refr_e%0d", k + 1), refractory, tbl[k].rf);
            check($sformatf("if_vmem_e%0d", k + 1), vmem_out, tbl[k].vm);
        end

        // Leak decay; isyn stays nonzero but in_valid=0 must mask it.
        do_reset();
        drive(1'b1, 1'b1, 32'd80, 8'd100, 2'd0);
        step();
        check("leak_vmem_e1", vmem_out, 8'd0);
        drive(1'b1, 1'b0, 32'd80, 8'd100, 2'd0);
        for (int i = 0; i < 15; i++) begin
            step();
            check($sformatf("leak_vmem_%0d", i), vmem_out, leak_exp[i]);
            check($sformatf("leak_spike_%0d", i), spike, 4'b0000);
        end

        // Saturation: 200-50+200 clamps to 255 and fires at threshold 255.
        do_reset();
        drive(1'b1, 1'b1, 32'd200 << 8, 8'd255, 2'd1);
        step();
        check("sat_spike_e1", spike, 4'b0000);
        step();
        check("sat_spike_e2", spike, 4'b0010);
        check("sat_vmem_e2", vmem_out, 8'd200);
        drive(1'b1, 1'b0, 32'd0, 8'd255, 2'd1);
        step();
        check("sat_vmem_e3", vmem_out, 8'd0);
        check("sat_refr_e3", refractory, 4'b0010);

        // Independence: ch0=60, ch1=0, ch2=50, ch3=49 at threshold 50.
        do_reset();
        drive(1'b1, 1'b1, {8'd49, 8'd50, 8'd0, 8'd60}, 8'd50, 2'd3);
        step();
        check("ind_spike", spike, 4'b0101);
        check("ind_refr", refractory, 4'b0101);
        drive(1'b1, 1'b0, 32'd0, 8'd50, 2'd3);
        step();
        check("ind_v3", vmem_out, 8'd49);
        check("ind_spike_e2", spike, 4'b0000);
        vmem_sel = 2'd1;
        step();
        check("ind_v1", vmem_out, 8'd0);

        // Enable freeze at v=53, then resume.
        do_reset();
        drive(1'b1, 1'b1, 32'd30, 8'd100, 2'd0);
        repeat (2) step();
        check("frz_vmem_pre", vmem_out, 8'd30);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("frz_vmem_%0d", i), vmem_out, 8'd30);
            check($sformatf("frz_spike_%0d", i), spike, 4'b0000);
            check($sformatf("frz_refr_%0d", i), refractory, 4'b0000);
        end
        en = 1'b1;
        step();
        check("frz_resume_53", vmem_out, 8'd53);
        step();
        check("frz_resume_70", vmem_out, 8'd70);

        // Freeze during refractory, then async reset with cnt=2.
        do_reset();
        drive(1'b1, 1'b1, 32'd30, 8'd100, 2'd0);
        repeat (6) step();
        check("ar_spike_e6", spike, 4'b0001);
        en = 1'b0;
        repeat (2) step();
        check("ar_frz_spike", spike, 4'b0000);
        check("ar_frz_refr", refractory, 4'b0001);
        en = 1'b1;
        step();
        check("ar_refr_cnt2", refractory, 4'b0001);
        #2 rst_n = 1'b1;
        #1;
        check("ar_async_refr", refractory, 4'b0000);
        check("ar_async_vmem", vmem_out, 8'd0);
        check("ar_async_spike", spike, 4'b0000);
        #1 rst_n = 1'b0;
        step();
        check("ar_post_refr", refractory, 4'b0000);
        check("ar_post_spike", spike, 4'b0000);
        step();
        check("ar_post_v30", vmem_out, 8'd30);

        // threshold=0: fire on every non-refractory enabled edge (period REFRACT+1).
        do_reset();
        drive(1'b1, 1'b0, 32'd0, 8'd0, 2'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("thr0_spike_%0d", i), spike, (i % 4 == 0) ? 4'b1111 : 4'b0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
